// File: rtl/sid_write_sched.sv
// ---------------------------------------------------------------------------
// sid_write_sched
//
// Write scheduler for the SID register bus. Two requesters (0 = host bus
// bridge, 1 = tune player/sequencer) are merged round-robin into a small
// FIFO. Entries are issued to the SID write port one at a time, and
// successive issues are held at least SPACING clkEn ticks apart.
//
// Parameters:
//   DEPTH   : FIFO entries (power of two, >= 2)
//   SPACING : minimum clkEn ticks between issued writes (>= 1)
//
// Ports:
//   clk                        master clock
//   iRst                       asynchronous active-high reset
//   clkEn                      1 MHz enable, one clk wide
//   iFlush                     synchronous clear of FIFO and spacing counter
//   iValid0/iAddr0/iData0      requester 0 write request
//   oReady0                    requester 0 accepted when iValid0 also high
//   iValid1/iAddr1/iData1      requester 1 write request
//   oReady1                    requester 1 accepted when iValid1 also high
//   oWE/oAddr/oDataW           registered SID write port (oWE one clk wide)
//   oLevel                     registered FIFO occupancy
// ---------------------------------------------------------------------------
module sid_write_sched #(
    parameter int DEPTH   = 4,
    parameter int SPACING = 1
) (
    input  logic                     clk,
    input  logic                     iRst,
    input  logic                     clkEn,
    input  logic                     iFlush,
    input  logic                     iValid0,
    input  logic [4:0]               iAddr0,
    input  logic [7:0]               iData0,
    output logic                     oReady0,
    input  logic                     iValid1,
    input  logic [4:0]               iAddr1,
    input  logic [7:0]               iData1,
    output logic                     oReady1,
    output logic                     oWE,
    output logic [4:0]               oAddr,
    output logic [7:0]               oDataW,
    output logic [$clog2(DEPTH):0]   oLevel
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SPACING) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic [LW-1:0]   level_next;
    logic [CW-1:0]   cnt_reg;
    logic            rr_reg;

    // Each entry is {addr[4:0], data[7:0]}.
    logic [12:0]     mem [DEPTH];

    logic            full;
    logic            empty;
    logic [1:0]      valid_vec;
    logic [1:0]      ready_vec;
    logic [1:0]      push_vec;
    logic            push;
    logic            pop;
    logic [12:0]     push_word;

    // Flags decode only the registered level, never the current requests.
    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);

    assign valid_vec = {iValid1, iValid0};

    // A requester is ready when it owns the round-robin turn, or when the
    // other requester is not asking. Both valids high grants only one.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ready_vec[gi] = !full && !iFlush &&
                                   ((rr_reg == 1'(gi)) || !valid_vec[1-gi]);
            assign push_vec[gi]  = valid_vec[gi] & ready_vec[gi];
        end
    endgenerate

    assign oReady0   = ready_vec[0];
    assign oReady1   = ready_vec[1];
    assign push      = |push_vec;
    assign push_word = push_vec[1] ? {iAddr1, iData1} : {iAddr0, iData0};

    // Pops only from IDLE, so oWE can never be high two cycles in a row.
    assign pop = (state_reg == IDLE) && clkEn && !empty &&
                 (cnt_reg == '0) && !iFlush;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    assign oLevel = level_reg;

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            cnt_reg    <= '0;
            rr_reg     <= 1'b0;
            oWE        <= 1'b0;
            oAddr      <= '0;
            oDataW     <= '0;
        end else begin
            // Turn passes to the other requester after each accepted write.
            if (push_vec[0]) begin
                rr_reg <= 1'b1;
            end else if (push_vec[1]) begin
                rr_reg <= 1'b0;
            end

            if (iFlush) begin
                // A pulse already on oWE still ends after its single cycle.
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
                cnt_reg    <= '0;
                state_reg  <= IDLE;
                oWE        <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                level_reg <= level_next;

                if (pop) begin
                    cnt_reg <= CW'(SPACING - 1);
                end else if (clkEn && (cnt_reg != '0)) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end

                case (state_reg)
                    IDLE: begin
                        if (pop) begin
                            state_reg <= ISSUE;
                            oWE       <= 1'b1;
                            oAddr     <= mem[rd_ptr_reg][12:8];
                            oDataW    <= mem[rd_ptr_reg][7:0];
                        end
                    end
                    ISSUE: begin
                        state_reg <= IDLE;
                        oWE       <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        oWE       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sid_write_sched.sv
// ---------------------------------------------------------------------------
// tb_sid_write_sched
//
// Directed bench for sid_write_sched (DEPTH=4, SPACING=3). A queue-based
// model tracks what the scheduler must do; a compare process checks every
// cycle, and directed scenarios pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_sid_write_sched;

    localparam int DEPTH   = 4;
    localparam int SPACING = 3;

    logic       clk;
    logic       iRst;
    logic       clkEn;
    logic       iFlush;
    logic       iValid0;
    logic [4:0] iAddr0;
    logic [7:0] iData0;
    logic       oReady0;
    logic       iValid1;
    logic [4:0] iAddr1;
    logic [7:0] iData1;
    logic       oReady1;
    logic       oWE;
    logic [4:0] oAddr;
    logic [7:0] oDataW;
    logic [2:0] oLevel;

    sid_write_sched #(
        .DEPTH   (DEPTH),
        .SPACING (SPACING)
    ) dut (
        .clk     (clk),
        .iRst    (iRst),
        .clkEn   (clkEn),
        .iFlush  (iFlush),
        .iValid0 (iValid0),
        .iAddr0  (iAddr0),
        .iData0  (iData0),
        .oReady0 (oReady0),
        .iValid1 (iValid1),
        .iAddr1  (iAddr1),
        .iData1  (iData1),
        .oReady1 (oReady1),
        .oWE     (oWE),
        .oAddr   (oAddr),
        .oDataW  (oDataW),
        .oLevel  (oLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ce_per   = 0;
    int ce_start = 0;

    // Observed issue log.
    int         we_cyc[$];
    logic [4:0] we_addr[$];
    logic [7:0] we_data[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [12:0] q[$];
    int          m_cnt = 0;
    bit          m_rr  = 0;
    bit          m_we  = 0;
    logic [4:0]  m_addr = '0;
    logic [7:0]  m_data = '0;

    function automatic bit exp_r0();
        return (q.size() != DEPTH) && !iFlush && (m_rr == 1'b0 || !iValid1);
    endfunction

    function automatic bit exp_r1();
        return (q.size() != DEPTH) && !iFlush && (m_rr == 1'b1 || !iValid0);
    endfunction

    always @(posedge clk or posedge iRst) begin
        bit r0, r1, p0, p1, pop;
        logic [12:0] e;
        if (iRst) begin
            q.delete();
            m_cnt = 0; m_rr = 0; m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            r0 = exp_r0();
            r1 = exp_r1();
            p0 = iValid0 && r0;
            p1 = iValid1 && r1;
            if (iFlush) begin
                q.delete();
                m_cnt = 0;
                m_we  = 0;
            end else begin
                // A write goes out only when none is on the bus right now.
                pop = clkEn && (q.size() != 0) && (m_cnt == 0) && !m_we;
                if (pop) begin
                    e = q.pop_front();
                    m_addr = e[12:8];
                    m_data = e[7:0];
                    m_cnt  = SPACING - 1;
                end else if (clkEn && m_cnt > 0) begin
                    m_cnt--;
                end
                m_we = pop;
                if (p0)      q.push_back({iAddr0, iData0});
                else if (p1) q.push_back({iAddr1, iData1});
            end
            if (p0)      m_rr = 1;
            else if (p1) m_rr = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        #2;
        chk("we", oWE, m_we);
        chk("level", oLevel, q.size());
        chk("ready0", oReady0, exp_r0());
        chk("ready1", oReady1, exp_r1());
        if (oWE) begin
            chk("addr", oAddr, m_addr);
            chk("data", oDataW, m_data);
            we_cyc.push_back(cyc);
            we_addr.push_back(oAddr);
            we_data.push_back(oDataW);
            $display("write cyc=%0d addr=%02h data=%02h level=%0d", cyc, oAddr, oDataW, oLevel);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        cyc++;
        clkEn = (ce_per != 0) && (cyc >= ce_start) && (((cyc - ce_start) % ce_per) == 0);
    endtask

    task automatic wait_we(input int n, input int budget, input string name);
        for (int k = 0; k < budget && we_cyc.size() < n; k++) tick();
        chk(name, we_cyc.size(), n);
    endtask

    initial begin
        int n0, t0, i0, i1, maxlvl, seen;
        int grants[$];

        iRst = 1; clkEn = 0; iFlush = 0;
        iValid0 = 0; iAddr0 = '0; iData0 = '0;
        iValid1 = 0; iAddr1 = '0; iData1 = '0;
        tick(); tick();
        iRst = 0;
        tick();
        #1;
        chk("rst_we", oWE, 0);
        chk("rst_level", oLevel, 0);

        // ---- round-robin and backpressure: 6 writes from each requester
        ce_start = cyc + 1; ce_per = 4;
        n0 = we_cyc.size(); i0 = 0; i1 = 0; maxlvl = 0;
        for (int k = 0; k < 400 && !(i0 == 6 && i1 == 6 && we_cyc.size() - n0 >= 12); k++) begin
            tick();
            iValid0 = (i0 < 6); iAddr0 = 5'(i0);        iData0 = 8'(8'h10 + i0);
            iValid1 = (i1 < 6); iAddr1 = 5'(5'h10 + i1); iData1 = 8'(8'h80 + i1);
            #1;
            if (int'(oLevel) > maxlvl) maxlvl = oLevel;
            if (iValid0 && oReady0) begin grants.push_back(0); i0++; end
            else if (iValid1 && oReady1) begin grants.push_back(1); i1++; end
        end
        iValid0 = 0; iValid1 = 0;
        chk("rr_grants", grants.size(), 12);
        for (int i = 0; i < grants.size(); i++) chk("rr_order", grants[i], i % 2);
        chk("rr_issued", we_cyc.size() - n0, 12);
        chk("rr_maxlevel", maxlvl, 4);
        for (int i = 0; i < 12 && n0 + i < we_addr.size(); i++)
            chk("rr_issue_addr", we_addr[n0 + i], (i % 2) ? (16 + i / 2) : (i / 2));
        repeat (12) tick();

        // ---- single write: push at +10, clkEn every 16 from +16
        t0 = cyc; ce_start = t0 + 16; ce_per = 16; n0 = we_cyc.size();
        while (cyc < t0 + 50) begin
            tick();
            iValid0 = (cyc == t0 + 10); iAddr0 = 5'h04; iData0 = 8'h41;
        end
        chk("single_count", we_cyc.size() - n0, 1);
        if (we_cyc.size() > n0) begin
            chk("single_cycle", we_cyc[n0] - t0, 17);
            chk("single_addr", we_addr[n0], 8'h04);
            chk("single_data", we_data[n0], 8'h41);
        end
        #1;
        chk("single_level", oLevel, 0);

        // ---- spacing: 3 queued writes, clkEn every 4
        ce_per = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            iValid1 = 1; iAddr1 = 5'(5'h18 + k); iData1 = 8'(8'hC0 + k);
        end
        tick();
        iValid1 = 0;
        t0 = cyc; ce_start = t0 + 2; ce_per = 4; n0 = we_cyc.size();
        wait_we(n0 + 3, 60, "spacing_wait");
        if (we_cyc.size() >= n0 + 3) begin
            chk("spacing_first", we_cyc[n0] - t0, 3);
            chk("spacing_gap1", we_cyc[n0 + 1] - we_cyc[n0], 12);
            chk("spacing_gap2", we_cyc[n0 + 2] - we_cyc[n0 + 1], 12);
            chk("spacing_addr2", we_addr[n0 + 2], 8'h1A);
        end

        // ---- flush with cnt left non-zero and 3 entries queued
        repeat (10) tick();
        tick(); iValid0 = 1; iAddr0 = 5'h02; iData0 = 8'h22;
        tick(); iValid0 = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick(); #1;
            if (oWE) seen = 1;
        end
        chk("flush_pre_we", seen, 1);
        ce_per = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            iValid0 = 1; iAddr0 = 5'(5'h08 + k); iData0 = 8'(8'h90 + k);
        end
        tick();
        iData0 = 8'h9F; iFlush = 1;
        #1;
        chk("flush_ready0", oReady0, 0);
        n0 = we_cyc.size();
        tick();
        iFlush = 0; iValid0 = 0;
        #1;
        chk("flush_level", oLevel, 0);
        repeat (10) tick();
        chk("flush_no_we", we_cyc.size() - n0, 0);
        tick();
        t0 = cyc; iValid0 = 1; iAddr0 = 5'h07; iData0 = 8'h77;
        ce_start = t0 + 3; ce_per = 4;
        tick(); iValid0 = 0;
        wait_we(n0 + 1, 30, "flush_new_wait");
        if (we_cyc.size() > n0) begin
            chk("flush_new_cycle", we_cyc[n0] - t0, 4);
            chk("flush_new_addr", we_addr[n0], 8'h07);
        end

        // ---- asynchronous reset while oWE is high
        repeat (10) tick();
        tick(); iValid0 = 1; iAddr0 = 5'h03; iData0 = 8'h33;
        tick(); iAddr0 = 5'h04; iData0 = 8'h44;
        tick(); iValid0 = 0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick(); #1;
            if (oWE) seen = 1;
        end
        chk("rst_mid_saw_we", seen, 1);
        chk("rst_mid_level_before", oLevel, 1);
        iRst = 1;
        #1;
        chk("rst_mid_we", oWE, 0);
        chk("rst_mid_level", oLevel, 0);
        chk("rst_mid_addr", oAddr, 0);
        chk("rst_mid_data", oDataW, 0);
        tick(); tick();
        iRst = 0;
        tick();
        iValid0 = 1; iAddr0 = 5'h05; iData0 = 8'h55;
        iValid1 = 1; iAddr1 = 5'h15; iData1 = 8'h95;
        #1;
        chk("rst_rr_ready0", oReady0, 1);
        chk("rst_rr_ready1", oReady1, 0);
        n0 = we_cyc.size();
        tick();
        iValid0 = 0; iValid1 = 0;
        wait_we(n0 + 1, 30, "rst_rr_wait");
        if (we_cyc.size() > n0) chk("rst_rr_addr", we_addr[n0], 8'h05);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
